// File: rtl/mosby_fetch_decode.sv
// Instruction fetch/decode front end: pulls opcode and operand bytes from a
// valid/ready byte stream, classifies each instruction as single-byte,
// conditional relative branch or absolute jump, and issues one-cycle
// registered control pulses to the PC and branch logic.
module mosby_fetch_decode #(
  parameter logic [7:0] JMP_ABS_OPC = 8'h4C,
  parameter int         CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             byte_valid,
  input  logic [7:0]       byte_in,
  output logic             byte_ready,
  output logic             pc_inc_decoder,
  output logic             lower_byte_decoder,
  output logic             branch_con,
  output logic             branch_uncon,
  output logic [2:0]       branch_op,
  output logic [7:0]       operand_lo,
  output logic [7:0]       operand_hi,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {
    FETCH_OP,
    FETCH_LO,
    FETCH_HI,
    EXEC
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] opcode;
  logic       accept;
  logic       opcode_is_branch;
  logic       byte_is_branch;
  logic       byte_is_jump;
  logic       pc_inc_nxt;
  logic       lower_byte_nxt;
  logic       branch_con_nxt;
  logic       branch_uncon_nxt;
  logic       load_opcode;
  logic       load_lo;
  logic       load_hi;
  logic       load_branch_op;
  logic       count_en;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // EXEC is the redirect bubble; ready is also held low while in reset
  assign byte_ready       = rst && (state != EXEC);
  assign accept           = byte_valid && byte_ready;
  assign byte_is_branch   = (byte_in[4:0] == 5'b10000);
  assign byte_is_jump     = (byte_in == JMP_ABS_OPC);
  assign opcode_is_branch = (opcode[4:0] == 5'b10000);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FETCH_OP;
    else      state <= state_nxt;
  end

  // Next-state decode plus the pulse and load enables for the coming cycle
  always_comb begin
    state_nxt        = state;
    pc_inc_nxt       = 1'b0;
    lower_byte_nxt   = 1'b0;
    branch_con_nxt   = 1'b0;
    branch_uncon_nxt = 1'b0;
    load_opcode      = 1'b0;
    load_lo          = 1'b0;
    load_hi          = 1'b0;
    load_branch_op   = 1'b0;
    count_en         = 1'b0;
    case (state)
      FETCH_OP: begin
        if (accept) begin
          load_opcode = 1'b1;
          pc_inc_nxt  = 1'b1;
          if (byte_is_branch || byte_is_jump) state_nxt = FETCH_LO;
          else                                count_en  = 1'b1;
        end
      end
      FETCH_LO: begin
        if (accept) begin
          load_lo        = 1'b1;
          lower_byte_nxt = 1'b1;
          pc_inc_nxt     = 1'b1;
          if (opcode_is_branch) begin
            branch_con_nxt = 1'b1;
            load_branch_op = 1'b1;
            count_en       = 1'b1;
            state_nxt      = EXEC;
          end else begin
            state_nxt = FETCH_HI;
          end
        end
      end
      FETCH_HI: begin
        if (accept) begin
          load_hi          = 1'b1;
          branch_uncon_nxt = 1'b1;
          count_en         = 1'b1;
          state_nxt        = EXEC;
        end
      end
      EXEC:    state_nxt = FETCH_OP;
      default: state_nxt = FETCH_OP;
    endcase
  end

  // Registered pulses, captured bytes and the retired-instruction counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_inc_decoder     <= 1'b0;
      lower_byte_decoder <= 1'b0;
      branch_con         <= 1'b0;
      branch_uncon       <= 1'b0;
      branch_op          <= 3'b000;
      opcode             <= 8'h00;
      operand_lo         <= 8'h00;
      operand_hi         <= 8'h00;
      instr_count        <= '0;
    end else begin
      pc_inc_decoder     <= pc_inc_nxt;
      lower_byte_decoder <= lower_byte_nxt;
      branch_con         <= branch_con_nxt;
      branch_uncon       <= branch_uncon_nxt;
      if (load_opcode)    opcode      <= byte_in;
      if (load_lo)        operand_lo  <= byte_in;
      if (load_hi)        operand_hi  <= byte_in;
      if (load_branch_op) branch_op   <= opcode[7:5];
      if (count_en)       instr_count <= instr_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_mosby_fetch_decode.sv
// Self-checking bench for mosby_fetch_decode: a behavioural model predicts
// the output vector after every clock edge and queues it; the queued value
// is popped and compared once the DUT has produced that cycle's outputs.
module tb_mosby_fetch_decode;

  logic        clk;
  logic        rst;
  logic        byte_valid;
  logic [7:0]  byte_in;
  logic        byte_ready;
  logic        pc_inc_decoder;
  logic        lower_byte_decoder;
  logic        branch_con;
  logic        branch_uncon;
  logic [2:0]  branch_op;
  logic [7:0]  operand_lo;
  logic [7:0]  operand_hi;
  logic [15:0] instr_count;

  int checks;
  int errors;

  logic [39:0] exp_q[$];

  localparam int M_OP   = 0;
  localparam int M_LO   = 1;
  localparam int M_HI   = 2;
  localparam int M_EXEC = 3;

  int          m_state;
  logic [7:0]  m_opc;
  logic [7:0]  m_lo;
  logic [7:0]  m_hi;
  logic [2:0]  m_bop;
  logic [15:0] m_cnt;

  mosby_fetch_decode #(
    .JMP_ABS_OPC (8'h4C),
    .CNT_W       (16)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .byte_valid         (byte_valid),
    .byte_in            (byte_in),
    .byte_ready         (byte_ready),
    .pc_inc_decoder     (pc_inc_decoder),
    .lower_byte_decoder (lower_byte_decoder),
    .branch_con         (branch_con),
    .branch_uncon       (branch_uncon),
    .branch_op          (branch_op),
    .operand_lo         (operand_lo),
    .operand_hi         (operand_hi),
    .instr_count        (instr_count)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [39:0] pack(input logic rdy, input logic pc, input logic lop,
                                       input logic bc, input logic bu, input logic [2:0] bop,
                                       input logic [7:0] lo, input logic [7:0] hi,
                                       input logic [15:0] cnt);
    return {rdy, pc, lop, bc, bu, bop, lo, hi, cnt};
  endfunction

  function automatic logic [39:0] observed();
    return pack(byte_ready, pc_inc_decoder, lower_byte_decoder, branch_con, branch_uncon,
                branch_op, operand_lo, operand_hi, instr_count);
  endfunction

  task automatic check_output(input string tag, input logic [39:0] got, input logic [39:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got rdy/pc/lo/bc/bu=%b bop=%h lo=%h hi=%h cnt=%h  exp rdy/pc/lo/bc/bu=%b bop=%h lo=%h hi=%h cnt=%h",
               tag, got[39:35], got[34:32], got[31:24], got[23:16], got[15:0],
               exp[39:35], exp[34:32], exp[31:24], exp[23:16], exp[15:0]);
    end
  endtask

  task automatic model_reset();
    m_state = M_OP;
    m_opc   = 8'h00;
    m_lo    = 8'h00;
    m_hi    = 8'h00;
    m_bop   = 3'b000;
    m_cnt   = 16'h0000;
  endtask

  // Drive one cycle of stimulus, predict the post-edge outputs, then compare
  task automatic apply_stimulus(input string tag, input logic valid, input logic [7:0] data);
    logic        acc;
    logic        pc;
    logic        lop;
    logic        bc;
    logic        bu;
    logic [39:0] exp;
    byte_valid = valid;
    byte_in    = data;
    acc = valid && (m_state != M_EXEC);
    pc = 1'b0; lop = 1'b0; bc = 1'b0; bu = 1'b0;
    case (m_state)
      M_OP: if (acc) begin
        m_opc = data;
        pc    = 1'b1;
        if (data[4:0] == 5'b10000 || data == 8'h4C) m_state = M_LO;
        else m_cnt = m_cnt + 16'd1;
      end
      M_LO: if (acc) begin
        m_lo = data;
        lop  = 1'b1;
        pc   = 1'b1;
        if (m_opc[4:0] == 5'b10000) begin
          bc      = 1'b1;
          m_bop   = m_opc[7:5];
          m_cnt   = m_cnt + 16'd1;
          m_state = M_EXEC;
        end else begin
          m_state = M_HI;
        end
      end
      M_HI: if (acc) begin
        m_hi    = data;
        bu      = 1'b1;
        m_cnt   = m_cnt + 16'd1;
        m_state = M_EXEC;
      end
      default: m_state = M_OP;
    endcase
    exp_q.push_back(pack(m_state != M_EXEC, pc, lop, bc, bu, m_bop, m_lo, m_hi, m_cnt));
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s scoreboard empty", tag);
    end else begin
      exp = exp_q.pop_front();
      check_output(tag, observed(), exp);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b0;
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    model_reset();

    // Outputs during power-on reset
    #3;
    check_output("reset_init", observed(), 40'h0);
    @(negedge clk);
    rst = 1'b1;

    // Two single-byte opcodes back to back
    apply_stimulus("nop1", 1'b1, 8'hEA);
    apply_stimulus("nop2", 1'b1, 8'hEA);
    apply_stimulus("idle_a", 1'b0, 8'h00);

    // Conditional branch, then a byte offered during EXEC that must be ignored
    apply_stimulus("br_op", 1'b1, 8'hF0);
    apply_stimulus("br_lo", 1'b1, 8'h05);
    apply_stimulus("br_exec", 1'b1, 8'hEA);
    apply_stimulus("after_br", 1'b1, 8'hEA);
    apply_stimulus("idle_b", 1'b0, 8'h00);

    // Absolute jump with EXEC bubble
    apply_stimulus("jmp_op", 1'b1, 8'h4C);
    apply_stimulus("jmp_lo", 1'b1, 8'h34);
    apply_stimulus("jmp_hi", 1'b1, 8'h12);
    apply_stimulus("jmp_exec", 1'b0, 8'h00);
    apply_stimulus("idle_c", 1'b0, 8'h00);

    // Branch with a five-cycle stall before the offset byte
    apply_stimulus("stall_op", 1'b1, 8'h10);
    for (int i = 0; i < 5; i++) apply_stimulus("stall_wait", 1'b0, 8'hAA);
    apply_stimulus("stall_lo", 1'b1, 8'hFE);
    apply_stimulus("stall_exec", 1'b0, 8'h00);

    // Reset asserted while waiting for the jump high byte
    apply_stimulus("rj_op", 1'b1, 8'h4C);
    apply_stimulus("rj_lo", 1'b1, 8'h00);
    byte_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_output("reset_async", observed(), 40'h0);
    model_reset();
    @(negedge clk);
    check_output("reset_hold", observed(), 40'h0);
    rst = 1'b1;
    apply_stimulus("post_rst", 1'b1, 8'h12);
    apply_stimulus("post_rst_idle", 1'b0, 8'h00);

    // Fill the counter to all-ones, then one more accept wraps it to zero
    while (m_cnt != 16'hFFFF) apply_stimulus("fill", 1'b1, 8'hEA);
    apply_stimulus("wrap", 1'b1, 8'hEA);
    check_output("wrap_zero", {24'h0, instr_count}, 40'h0);
    apply_stimulus("wrap_idle", 1'b0, 8'h00);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain got=%0d entries exp=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mosby_fetch_decode.md
MOSBY_FETCH_DECODE -- requirements
Module: mosby_fetch_decode

Interface
REQ-001 SHALL have parameter JMP_ABS_OPC, default 8'h4C, opcode decoded as unconditional absolute jump.
REQ-002 SHALL have parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port byte_valid  input  1  instruction byte on byte_in is valid.
REQ-006 SHALL have port byte_in  input  8  instruction stream byte from memory.
REQ-007 SHALL have port byte_ready  output  1  block accepts byte_in this cycle; a byte is consumed on an edge where byte_valid and byte_ready are both 1.
REQ-008 SHALL have port pc_inc_decoder  output  1  one-cycle pulse: PC advances by one.
REQ-009 SHALL have port lower_byte_decoder  output  1  one-cycle pulse: operand_lo holds a newly captured low operand byte.
REQ-010 SHALL have port branch_con  output  1  one-cycle pulse: conditional relative branch, evaluate branch_op against status.
REQ-011 SHALL have port branch_uncon  output  1  one-cycle pulse: unconditional jump to {operand_hi,operand_lo}.
REQ-012 SHALL have port branch_op  output  3  branch condition select, = opcode[7:5].
REQ-013 SHALL have ports operand_lo and operand_hi  output  8 each  captured operand bytes.
REQ-014 SHALL have port instr_count  output  CNT_W  retired-instruction count.

Function
REQ-015 SHALL implement FSM states FETCH_OP, FETCH_LO, FETCH_HI, EXEC; byte_ready = 1 in FETCH_OP/FETCH_LO/FETCH_HI, 0 in EXEC and whenever rst is low.
REQ-016 SHALL hold state and all registers unchanged on any edge without an accept; byte_valid while byte_ready=0 is ignored, not buffered.
REQ-017 SHALL classify the opcode accepted in FETCH_OP: branch if opcode[4:0]=5'b10000, jump if opcode=JMP_ABS_OPC, otherwise single-byte.
REQ-018 SHALL, on every FETCH_OP accept, latch the opcode and pulse pc_inc_decoder in the following cycle.
REQ-019 SHALL, for single-byte opcodes, remain in FETCH_OP and increment instr_count on the accept edge (back-to-back accepts allowed every cycle).
REQ-020 SHALL, for branch/jump opcodes, go to FETCH_LO.
REQ-021 SHALL, on FETCH_LO accept, load operand_lo and pulse lower_byte_decoder and pc_inc_decoder.
REQ-022 SHALL, on FETCH_LO accept for a branch, also pulse branch_con with branch_op = opcode[7:5] in the same cycle, increment instr_count, go to EXEC.
REQ-023 SHALL, on FETCH_LO accept for a jump, go to FETCH_HI.
REQ-024 SHALL, on FETCH_HI accept, load operand_hi, pulse branch_uncon, NOT pulse pc_inc_decoder, increment instr_count, go to EXEC.
REQ-025 SHALL leave EXEC unconditionally after exactly one cycle to FETCH_OP (one-cycle fetch bubble for the PC redirect).
REQ-026 SHALL drive all pulse outputs registered, high for exactly one cycle per event, never two in a row from one accept.
REQ-027 SHALL hold branch_op, operand_lo, operand_hi stable until overwritten by the next capture.
REQ-028 SHALL wrap instr_count from all-ones to zero without flag.
REQ-029 SHALL, on a stall (byte_valid=0) in FETCH_LO/FETCH_HI, wait indefinitely with no pulses.

Reset
REQ-030 SHALL, while rst=0, force state FETCH_OP and byte_ready, pc_inc_decoder, lower_byte_decoder, branch_con, branch_uncon, branch_op, operand_lo, operand_hi, instr_count to 0, asynchronously.
REQ-031 SHALL discard any partially fetched instruction when reset asserts mid-operation; first accept after release is treated as an opcode.

Verification
REQ-032 Bytes 8'hEA,8'hEA continuous valid -> two pc_inc_decoder pulses on consecutive cycles, instr_count=2, no branch pulses.
REQ-033 Bytes 8'hF0,8'h05 -> pc_inc pulse; then lower_byte_decoder+pc_inc+branch_con together, branch_op=3'b111, operand_lo=8'h05; next cycle byte_ready=0.
REQ-034 Bytes 8'h4C,8'h34,8'h12 -> lower_byte_decoder with operand_lo=8'h34, then branch_uncon with operand_hi=8'h12 and pc_inc_decoder=0, EXEC bubble, instr_count=1.
REQ-035 8'h10 accepted, byte_valid low 5 cycles, then 8'hFE -> no pulses during stall; branch_con with branch_op=3'b000, operand_lo=8'hFE.
REQ-036 8'h4C,8'h00 accepted, rst low mid-FETCH_HI -> all outputs 0 immediately; after release, 8'h12 decoded as single-byte opcode, no branch_uncon.
REQ-037 instr_count preloaded by 65535 single-byte accepts plus one -> instr_count wraps to 0.
